btn_conditioner: RTL and testbench

// - Upstream input stage for the reaction-timer top level. Conditions the raw push-buttons
//   (start, stop, clear) before the state machine, counter and display mux consume them.
// - For each button channel:
//   - synchronises the raw input into clk;
//   - debounces it, requiring DB_TICKS consecutive stable samples;
//   - emits a clean level, plus one-cycle rise and fall pulses.

---
 rtl/btn_pkg.sv | 20 ++
 rtl/btn_debounce_ch.sv | 105 ++++++++++
 rtl/btn_conditioner.sv | 32 +++
 tb/tb_btn_conditioner.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning path.
// Imported by btn_debounce_ch and btn_conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        ZERO,
        WAIT1,
        ONE,
        WAIT0
    } db_state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DB_TICKS_DEF    = 1_000_000;

    // Debounce counter width; a single tick still needs one bit.
    function automatic int cnt_width(input int ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce FSM, counter, registered outputs.
// Ports: clk, rst_n, btn_raw (async in), btn_level / btn_rise / btn_fall (out).
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_TICKS    = DB_TICKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    localparam int CW = cnt_width(DB_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    db_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
    assign s      = sync_q[SYNC_STAGES-1];

    // State register (plus synchroniser, counter and output flops)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= ZERO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic. The counter only advances inside WAIT*,
    // and those states always exit at CNT_LAST, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ZERO: begin
                if (s) begin
                    state_d = WAIT1;
                    cnt_d   = '0;
                end
            end
            WAIT1: begin
                if (!s) begin
                    state_d = ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ONE: begin
                if (!s) begin
                    state_d = WAIT0;
                    cnt_d   = '0;
                end
            end
            WAIT0: begin
                if (s) begin
                    state_d = ONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ZERO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ZERO;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered
    // level and pulse appear on the same edge the state changes.
    always_comb begin
        level_d = (state_d == ONE) || (state_d == WAIT0);
        rise_d  = (state_q == WAIT1) && (state_d == ONE);
        fall_d  = (state_q == WAIT0) && (state_d == ZERO);
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw push-buttons into debounced levels and edge pulses.
// Ports: clk, rst_n, btn_raw[N_BTN] in; btn_level/btn_rise/btn_fall[N_BTN] out.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN       = 3,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_TICKS    = DB_TICKS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_TICKS   (DB_TICKS)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_raw  (btn_raw[g]),
            .btn_level(btn_level[g]),
            .btn_rise (btn_rise[g]),
            .btn_fall (btn_fall[g])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with N_BTN=3, SYNC_STAGES=2, DB_TICKS=4.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_btn_conditioner;

    logic       clk;
    logic       rst_n;
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_rise;
    logic [2:0] btn_fall;

    int n_checks = 0;
    int n_fail   = 0;

    btn_conditioner #(
        .N_BTN      (3),
        .SYNC_STAGES(2),
        .DB_TICKS   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] raw;
        logic [2:0] level;
        logic [2:0] rise;
        logic [2:0] fall;
    } vec_t;

    vec_t tbl [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] act,
                       input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [2:0] l,
                           input logic [2:0] r, input logic [2:0] f);
        chk({name, " level"}, btn_level, l);
        chk({name, " rise"}, btn_rise, r);
        chk({name, " fall"}, btn_fall, f);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        btn_raw = 3'b000;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_level(input int bitn, input string name);
        for (int k = 0; k < 20 && !btn_level[bitn]; k++) step();
        chk(name, btn_level & (3'b001 << bitn), 3'b001 << bitn);
    endtask

    logic p [6];
    int   nr;

    initial begin
        // Test 1 vectors: raw[0] raised before edge 1, held
        tbl[0] = '{3'b001, 3'b000, 3'b000, 3'b000};
        tbl[1] = '{3'b001, 3'b000, 3'b000, 3'b000};
        tbl[2] = '{3'b001, 3'b000, 3'b000, 3'b000};
        tbl[3] = '{3'b001, 3'b000, 3'b000, 3'b000};
        tbl[4] = '{3'b001, 3'b000, 3'b000, 3'b000};
        tbl[5] = '{3'b001, 3'b000, 3'b000, 3'b000};
        tbl[6] = '{3'b001, 3'b001, 3'b001, 3'b000};
        tbl[7] = '{3'b001, 3'b001, 3'b000, 3'b000};
        tbl[8] = '{3'b001, 3'b001, 3'b000, 3'b000};
        tbl[9] = '{3'b001, 3'b001, 3'b000, 3'b000};
        p = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst_n   = 1'b1;
        btn_raw = 3'b000;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("reset", 3'b000, 3'b000, 3'b000);
        step();
        step();
        rst_n = 1'b1;

        // 1. single press, table driven
        for (int i = 0; i < 10; i++) begin
            btn_raw = tbl[i].raw;
            step();
            chk_all($sformatf("t1 e%0d", i + 1),
                    tbl[i].level, tbl[i].rise, tbl[i].fall);
        end

        // 3. glitch: 3 low cycles never reach the terminal count
        btn_raw = 3'b000;
        for (int e = 1; e <= 11; e++) begin
            if (e == 4) btn_raw = 3'b001;
            step();
            chk_all($sformatf("t3 e%0d", e), 3'b001, 3'b000, 3'b000);
        end

        // 2. bounce on channel 1; last 0->1 is driven before edge 6
        do_reset();
        nr = 0;
        for (int e = 1; e <= 15; e++) begin
            btn_raw = (e <= 6) ? {1'b0, p[e-1], 1'b0} : 3'b010;
            step();
            nr += int'(btn_rise[1]);
            if (e < 12)
                chk_all($sformatf("t2 e%0d", e), 3'b000, 3'b000, 3'b000);
            else if (e == 12)
                chk_all("t2 e12", 3'b010, 3'b010, 3'b000);
            else
                chk_all($sformatf("t2 e%0d", e), 3'b010, 3'b000, 3'b000);
        end
        chk("t2 rise count", 3'(nr), 3'd1);

        // 4. release on channel 2
        do_reset();
        btn_raw = 3'b100;
        wait_level(2, "t4 level up");
        step();
        btn_raw = 3'b000;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (e < 7)
                chk_all($sformatf("t4 e%0d", e), 3'b100, 3'b000, 3'b000);
            else if (e == 7)
                chk_all("t4 e7", 3'b000, 3'b000, 3'b100);
            else
                chk_all($sformatf("t4 e%0d", e), 3'b000, 3'b000, 3'b000);
        end

        // 5. reset while channel 0 is in WAIT1, channel 2 high
        btn_raw = 3'b100;
        wait_level(2, "t5 ch2 up");
        step();
        btn_raw = 3'b101;
        for (int e = 0; e < 4; e++) step();
        chk("t5 pre level", btn_level, 3'b100);
        rst_n = 1'b0;
        #1;
        chk_all("t5 async", 3'b000, 3'b000, 3'b000);
        step();
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e < 7)
                chk_all($sformatf("t5 e%0d", e), 3'b000, 3'b000, 3'b000);
            else if (e == 7)
                chk_all("t5 e7", 3'b101, 3'b101, 3'b000);
            else
                chk_all("t5 e8", 3'b101, 3'b000, 3'b000);
        end

        // 6. all three channels together
        do_reset();
        btn_raw = 3'b111;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e < 7)
                chk_all($sformatf("t6 e%0d", e), 3'b000, 3'b000, 3'b000);
            else if (e == 7)
                chk_all("t6 e7", 3'b111, 3'b111, 3'b000);
            else
                chk_all("t6 e8", 3'b111, 3'b000, 3'b000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
